// File: rtl/arb_issue_buf.sv
// arb_issue_buf: slot buffer around an age-matrix/matrix-arbiter pair giving oldest-first issue
// through a registered valid/ready output stage.
module arb_issue_buf #(
    parameter int WIDTH = 4,
    parameter int DATA_W = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rdy,
    output logic              alloc_en,
    output logic [WIDTH-1:0]  v_alloc,
    output logic [WIDTH-1:0]  v_vld,
    input  logic [WIDTH-1:0]  v_grant,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_rdy,
    output logic [IDX_W:0]    count,
    output logic              err
);
    logic [WIDTH-1:0]  r_occ;
    logic [DATA_W-1:0] r_mem [WIDTH];
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_err;
    logic              w_ok;
    logic              w_acc;
    logic              w_onehot;
    logic              w_gnt_ok;
    logic              w_gnt_err;
    logic [WIDTH-1:0]  w_free;
    logic [IDX_W-1:0]  w_aidx;
    logic [IDX_W-1:0]  w_gidx;
    logic [IDX_W:0]    w_cnt;

    assign w_ok      = ~r_out_vld | out_rdy;
    assign in_rdy    = ~&r_occ;
    assign w_acc     = in_vld & in_rdy;
    // isolates the lowest clear bit of the occupancy vector
    assign w_free    = ~r_occ & (r_occ + 1'b1);
    assign alloc_en  = w_acc;
    assign v_alloc   = w_acc ? w_free : '0;
    assign v_vld     = r_occ & {WIDTH{w_ok}};
    assign w_onehot  = |v_grant & ~|(v_grant & (v_grant - 1'b1));
    assign w_gnt_ok  = w_ok & w_onehot & |(v_grant & r_occ);
    assign w_gnt_err = |v_grant & ~w_gnt_ok;
    assign out_vld   = r_out_vld;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign err       = r_err;
    assign count     = w_cnt;

    always_comb begin
        w_aidx = '0;
        w_gidx = '0;
        w_cnt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_aidx = w_free[i] ? IDX_W'(i) : w_aidx;
            w_gidx = v_grant[i] ? IDX_W'(i) : w_gidx;
            w_cnt  = w_cnt + {{IDX_W{1'b0}}, r_occ[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_mem[w_aidx] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ      <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_occ <= (r_occ | v_alloc) & ~(w_gnt_ok ? v_grant : '0);
            if (w_gnt_ok) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_mem[w_gidx];
                r_out_idx  <= w_gidx;
            end else if (out_rdy) begin
                r_out_vld  <= 1'b0;
            end
            if (w_gnt_err) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_arb_issue_buf.sv
// tb_arb_issue_buf: random and directed traffic against a slot/age-queue reference model;
// the bench plays the oldest-first arbiter and a monitor checks issued payloads from a scoreboard.
module tb_arb_issue_buf;
    typedef struct {
        logic [7:0] d;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_vld = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_rdy = 1'b0;
    logic [3:0] v_grant = '0;
    logic       in_rdy;
    logic       alloc_en;
    logic [3:0] v_alloc;
    logic [3:0] v_vld;
    logic       out_vld;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic [2:0] count;
    logic       err;

    int n_chk = 0;
    int n_pass = 0;
    bit         m_occ [4];
    logic [7:0] m_mem [4];
    int         age_q [$];
    bit         m_ovld = 0;
    bit         m_err = 0;
    exp_t       sb [$];
    exp_t       mon_e;

    arb_issue_buf #(.WIDTH(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .alloc_en(alloc_en), .v_alloc(v_alloc), .v_vld(v_vld), .v_grant(v_grant),
        .out_vld(out_vld), .out_data(out_data), .out_idx(out_idx), .out_rdy(out_rdy),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e.d);
                chk("out_idx", out_idx, mon_e.idx);
            end
        end
    end

    // gmode: 0 no grant, 1 oldest occupied slot when eligible, 2 forced grant fg
    task automatic step(input bit iv, input logic [7:0] d, input bit ordy, input int gmode,
                        input logic [3:0] fg);
        bit ok, acc, good;
        int slot, gi;
        logic [3:0] occv, g;
        in_vld = iv;
        in_data = d;
        out_rdy = ordy;
        ok = !m_ovld || ordy;
        slot = -1;
        occv = '0;
        for (int i = 0; i < 4; i++) begin
            occv[i] = m_occ[i];
            if (!m_occ[i] && slot < 0) slot = i;
        end
        g = '0;
        if (gmode == 1 && ok && age_q.size() > 0) g = 4'b0001 << age_q[0];
        else if (gmode == 2) g = fg;
        v_grant = g;
        #1;
        acc = iv && slot >= 0;
        chk("in_rdy", in_rdy, slot >= 0);
        chk("alloc_en", alloc_en, acc);
        chk("v_alloc", v_alloc, acc ? (32'd1 << slot) : 32'd0);
        chk("v_vld", v_vld, ok ? occv : 4'b0000);
        chk("count", count, age_q.size());
        chk("err", err, m_err);
        chk("out_vld", out_vld, m_ovld);
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        good = ok && $countones(g) == 1 && m_occ[gi];
        if (good) sb.push_back('{m_mem[gi], gi});
        @(posedge clk);
        if (good) begin
            m_occ[gi] = 0;
            for (int k = 0; k < age_q.size(); k++)
                if (age_q[k] == gi) begin
                    age_q.delete(k);
                    break;
                end
            m_ovld = 1;
        end else if (ordy) m_ovld = 0;
        if (g != 0 && !good) m_err = 1;
        if (acc) begin
            m_occ[slot] = 1;
            m_mem[slot] = d;
            age_q.push_back(slot);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) m_occ[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_err", err, 0);
        chk("rst_in_rdy", in_rdy, 1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0, 4'h0);
        step(0, 8'h00, 0, 1, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 1, 4'h0);
            chk("hold_data", out_data, 8'hA1);
            chk("hold_idx", out_idx, 0);
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 1, 4'h0);
        for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), 1, 0, 4'h0);
        step(0, 8'h00, 1, 1, 4'h0);
        step(1, 8'hB4, 1, 0, 4'h0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 1, 4'h0);
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 1, 0, 4'h0);
        step(1, 8'hC3, 1, 1, 4'h0);
        step(0, 8'h00, 0, 0, 4'h0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0 ? 1 : 0, 4'h0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 1, 4'h0);
        step(1, 8'hD0, 1, 0, 4'h0);
        step(1, 8'hD1, 1, 0, 4'h0);
        step(0, 8'h00, 1, 2, 4'b0011);
        step(0, 8'h00, 1, 2, 4'b0100);
        chk("err_sticky", err, 1);
        step(0, 8'h00, 1, 1, 4'h0);
        chk("err_held", err, 1);
        for (int i = 0; i < 6; i++) step(1, 8'($urandom), $urandom_range(0, 1), 1, 4'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_vld", out_vld, 0);
        chk("arst_err", err, 0);
        chk("arst_v_vld", v_vld, 0);
        in_vld = 1'b0;
        v_grant = '0;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) m_occ[i] = 0;
        age_q.delete();
        sb.delete();
        m_ovld = 0;
        m_err = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 1, 4'h0);
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 1, 4'h0);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
